// File: rtl/addsub_core_seq.sv
// addsub_core_seq: multi-cycle IEEE-754 single-precision add/subtract core.
// Handles only the normal-operand path: unpack, align, add/sub, normalize,
// and round-to-nearest-even. Zero/Inf/NaN operands produce a deterministic
// zero here because a later stage replaces the result for those operands.
// Handshake is valid/ready on both sides, with one operation in flight.
// Optional status flags are enabled by defining the macro ADDSUB_STATUS_EN.
module addsub_core_seq #(
  parameter int NORM_MAX = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] temp_result
`ifdef ADDSUB_STATUS_EN
  ,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inexact
`endif
);

  localparam int CW = $clog2(NORM_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t state, state_next;

  logic [31:0]       a_reg, b_reg;
  logic              op_reg;
  logic [26:0]       x_mant, y_mant;
  logic              res_sign;
  logic              eff_sub;
  logic signed [9:0] exp_w;
  logic [27:0]       mant;
  logic [CW-1:0]     norm_cnt;

  // Unpack the registered operands.
  // The larger magnitude becomes X so that the subtraction never goes negative.
  logic        sign_a, sign_b, special, a_ge_b;
  logic [7:0]  exp_a, exp_b, x_exp, y_exp, diff;
  logic [22:0] x_frac, y_frac;
  logic        x_sign;
  logic [26:0] y_full, y_shr, y_mask, y_aligned;
  logic        y_lost;

  // Swap and align. Bits shifted out of Y are collapsed into its sticky bit.
  always_comb begin
    sign_a  = a_reg[31];
    sign_b  = b_reg[31] ^ op_reg;
    exp_a   = a_reg[30:23];
    exp_b   = b_reg[30:23];
    special = (exp_a == 8'h00) || (exp_a == 8'hFF) ||
              (exp_b == 8'h00) || (exp_b == 8'hFF);
    a_ge_b  = (a_reg[30:0] >= b_reg[30:0]);
    x_exp   = a_ge_b ? exp_a : exp_b;
    y_exp   = a_ge_b ? exp_b : exp_a;
    x_frac  = a_ge_b ? a_reg[22:0] : b_reg[22:0];
    y_frac  = a_ge_b ? b_reg[22:0] : a_reg[22:0];
    x_sign  = a_ge_b ? sign_a : sign_b;
    diff    = x_exp - y_exp;
    y_full  = {1'b1, y_frac, 3'b000};
    y_shr   = y_full >> diff;
    y_mask  = (27'h1 << diff) - 27'h1;
    y_lost  = |(y_full & y_mask);
    if (diff >= 8'd27) begin
      y_aligned = 27'h1;
    end else begin
      y_aligned = {y_shr[26:1], y_shr[0] | y_lost};
    end
  end

  // Add or subtract the aligned mantissas. The extra top bit catches the carry.
  logic [27:0] sum;
  always_comb begin
    if (eff_sub) begin
      sum = {1'b0, x_mant} - {1'b0, y_mant};
    end else begin
      sum = {1'b0, x_mant} + {1'b0, y_mant};
    end
  end

  // Round to nearest even, renormalize on mantissa overflow, and then
  // replace the result with Inf or a flushed zero when the exponent is out of range.
  logic              g_bit, r_bit, s_bit, lsb_bit, inc;
  logic [24:0]       rnd;
  logic [23:0]       r_mant;
  logic signed [9:0] r_exp;
  logic              ovf, unf;
  logic [31:0]       round_word;
  always_comb begin
    g_bit   = mant[2];
    r_bit   = mant[1];
    s_bit   = mant[0];
    lsb_bit = mant[3];
    inc     = g_bit & (r_bit | s_bit | lsb_bit);
    rnd     = {1'b0, mant[26:3]} + {24'h0, inc};
    if (rnd[24]) begin
      r_mant = rnd[24:1];
      r_exp  = exp_w + 10'sd1;
    end else begin
      r_mant = rnd[23:0];
      r_exp  = exp_w;
    end
    ovf = (r_exp >= 10'sd255);
    unf = !ovf && (r_exp <= 10'sd0) && (mant[26:0] != 27'h0);
    if (ovf) begin
      round_word = {res_sign, 8'hFF, 23'h0};
    end else if (r_exp <= 10'sd0) begin
      round_word = {res_sign, 31'h0};
    end else begin
      round_word = {res_sign, r_exp[7:0], r_mant[22:0]};
    end
  end

  // Normalization is complete when there is a carry, the mantissa is zero,
  // the leading one is already at bit 26, or the iteration budget is used up.
  logic norm_done;
  always_comb begin
    norm_done = mant[27] || (mant == 28'h0) || mant[26] ||
                (norm_cnt == CW'(NORM_MAX));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ALIGN;
      end
      ALIGN:   state_next = special ? DONE : ADD;
      ADD:     state_next = NORM;
      NORM:    if (norm_done) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. Each stage updates only its own working values.
  // The result word is written only in ROUND or on the special-operand shortcut,
  // so it stays stable through DONE and afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg       <= 32'h0;
      b_reg       <= 32'h0;
      op_reg      <= 1'b0;
      x_mant      <= 27'h0;
      y_mant      <= 27'h0;
      res_sign    <= 1'b0;
      eff_sub     <= 1'b0;
      exp_w       <= 10'sd0;
      mant        <= 28'h0;
      norm_cnt    <= '0;
      temp_result <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= A;
            b_reg  <= B;
            op_reg <= op;
          end
        end
        ALIGN: begin
          x_mant   <= {1'b1, x_frac, 3'b000};
          y_mant   <= y_aligned;
          res_sign <= x_sign;
          eff_sub  <= sign_a ^ sign_b;
          exp_w    <= {2'b00, x_exp};
          norm_cnt <= '0;
          if (special) temp_result <= 32'h0;
        end
        ADD: begin
          mant <= sum;
        end
        NORM: begin
          if (mant[27]) begin
            mant  <= {1'b0, mant[27:2], mant[1] | mant[0]};
            exp_w <= exp_w + 10'sd1;
          end else if (mant == 28'h0) begin
            res_sign <= 1'b0;
            exp_w    <= 10'sd0;
          end else if (mant[26]) begin
            mant <= mant;
          end else if (norm_cnt == CW'(NORM_MAX)) begin
            mant     <= 28'h0;
            res_sign <= 1'b0;
            exp_w    <= 10'sd0;
          end else begin
            mant     <= {mant[26:0], 1'b0};
            exp_w    <= exp_w - 10'sd1;
            norm_cnt <= norm_cnt + CW'(1);
          end
        end
        ROUND: begin
          temp_result <= round_word;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ADDSUB_STATUS_EN
  // Status flags are captured with the rounded result and cleared when a new operation is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_ovf     <= 1'b0;
      flag_unf     <= 1'b0;
      flag_inexact <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      flag_ovf     <= 1'b0;
      flag_unf     <= 1'b0;
      flag_inexact <= 1'b0;
    end else if (state == ROUND) begin
      flag_ovf     <= ovf;
      flag_unf     <= unf;
      flag_inexact <= g_bit | r_bit | s_bit | ovf | unf;
    end
  end
`endif

endmodule

// File: tb/tb_addsub_core_seq.sv
// tb_addsub_core_seq: directed-vector bench for addsub_core_seq.
// Expected results are hand-computed IEEE-754 single-precision words.
module tb_addsub_core_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] temp_result;
`ifdef ADDSUB_STATUS_EN
  logic        flag_ovf, flag_unf, flag_inexact;
`endif

  int vectors = 0;
  int miscompares = 0;

  addsub_core_seq #(.NORM_MAX(26)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .A(A),
    .B(B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .temp_result(temp_result)
`ifdef ADDSUB_STATUS_EN
    ,
    .flag_ovf(flag_ovf),
    .flag_unf(flag_unf),
    .flag_inexact(flag_inexact)
`endif
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Present one operation and wait for out_valid. Latency is counted in edges after the accept edge.
  // If out_ready is high, also step through the edge that retires the result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic o,
                               output logic [31:0] res, output int lat);
    in_valid = 1'b1;
    A = a;
    B = b;
    op = o;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = temp_result;
    if (out_ready === 1'b1 && out_valid === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 1'b0;
    A = 32'h0;
    B = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    vectors++;
    if (temp_result !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_result got=%h exp=00000000", temp_result);
    end
  endtask

  task automatic test_add_sub();
    logic [31:0] res;
    int lat;
    applyStimulus(32'h3F800000, 32'h3F800000, 1'b0, res, lat);
    vectors++;
    if (res !== 32'h40000000) begin
      miscompares++;
      $display("[TB] FAIL one_plus_one got=%h exp=40000000", res);
    end
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("[TB] FAIL one_plus_one_latency got=%0d exp=4", lat);
    end
    applyStimulus(32'h3F800000, 32'h40000000, 1'b1, res, lat);
    vectors++;
    if (res !== 32'hBF800000) begin
      miscompares++;
      $display("[TB] FAIL one_minus_two got=%h exp=bf800000", res);
    end
    vectors++;
    if (lat !== 5) begin
      miscompares++;
      $display("[TB] FAIL one_minus_two_latency got=%0d exp=5", lat);
    end
  endtask

  task automatic test_long_norm();
    logic [31:0] res;
    int lat;
    applyStimulus(32'h3F800001, 32'h3F800000, 1'b1, res, lat);
    vectors++;
    if (res !== 32'h34000000) begin
      miscompares++;
      $display("[TB] FAIL long_norm got=%h exp=34000000", res);
    end
    vectors++;
    if (lat !== 27) begin
      miscompares++;
      $display("[TB] FAIL long_norm_latency got=%0d exp=27", lat);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] res;
    int lat;
    applyStimulus(32'h3F800000, 32'h33800000, 1'b0, res, lat);
    vectors++;
    if (res !== 32'h3F800000) begin
      miscompares++;
      $display("[TB] FAIL round_tie_even got=%h exp=3f800000", res);
    end
    applyStimulus(32'h3F800000, 32'h33C00000, 1'b0, res, lat);
    vectors++;
    if (res !== 32'h3F800001) begin
      miscompares++;
      $display("[TB] FAIL round_up got=%h exp=3f800001", res);
    end
  endtask

  task automatic test_special();
    logic [31:0] res;
    int lat;
    applyStimulus(32'h00000000, 32'h3F800000, 1'b0, res, lat);
    vectors++;
    if (res !== 32'h0 || lat >= 200) begin
      miscompares++;
      $display("[TB] FAIL special_zero got=%h lat=%0d exp=00000000", res, lat);
    end
  endtask

  task automatic test_overflow_cancel();
    logic [31:0] res;
    int lat;
    applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, res, lat);
    vectors++;
    if (res !== 32'h7F800000) begin
      miscompares++;
      $display("[TB] FAIL overflow_inf got=%h exp=7f800000", res);
    end
`ifdef ADDSUB_STATUS_EN
    vectors++;
    if (flag_ovf !== 1'b1 || flag_inexact !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_flags got ovf=%b inexact=%b exp=1,1", flag_ovf, flag_inexact);
    end
`endif
    applyStimulus(32'h3FC00000, 32'h3FC00000, 1'b1, res, lat);
    vectors++;
    if (res !== 32'h00000000) begin
      miscompares++;
      $display("[TB] FAIL exact_cancel got=%h exp=00000000", res);
    end
  endtask

  task automatic test_underflow();
    logic [31:0] res;
    int lat;
    applyStimulus(32'h00800000, 32'h00800001, 1'b1, res, lat);
    vectors++;
    if (res !== 32'h80000000) begin
      miscompares++;
      $display("[TB] FAIL underflow_flush got=%h exp=80000000", res);
    end
    vectors++;
    if (lat !== 27) begin
      miscompares++;
      $display("[TB] FAIL underflow_latency got=%0d exp=27", lat);
    end
`ifdef ADDSUB_STATUS_EN
    vectors++;
    if (flag_unf !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL underflow_flag got=%b exp=1", flag_unf);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    in_valid = 1'b1;
    A = 32'h40000000;
    B = 32'h40000000;
    op = 1'b0;
    @(posedge clk); #1;
    A = 32'h3F800000;
    B = 32'h3F800000;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (temp_result !== 32'h40800000) begin
      miscompares++;
      $display("[TB] FAIL busy_input_ignored got=%h exp=40800000", temp_result);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_in_ready got=%b exp=0", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL after_done got in_ready=%b out_valid=%b exp=1,0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL second_accept got in_ready=%b exp=0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (temp_result !== 32'h40000000 || lat !== 4) begin
      miscompares++;
      $display("[TB] FAIL second_op got=%h lat=%0d exp=40000000 lat=4", temp_result, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int lat;
    out_ready = 1'b0;
    applyStimulus(32'h3F800000, 32'h3F800000, 1'b0, res, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || temp_result !== 32'h40000000 || in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold cycle=%0d got v=%b r=%h rdy=%b exp 1,40000000,0",
                 i, out_valid, temp_result, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || temp_result !== 32'h40000000) begin
      miscompares++;
      $display("[TB] FAIL backpressure_release got v=%b rdy=%b r=%h exp 0,1,40000000",
               out_valid, in_ready, temp_result);
    end
  endtask

  task automatic test_reset_mid_norm();
    logic [31:0] res;
    int lat;
    in_valid = 1'b1;
    A = 32'h3F800001;
    B = 32'h3F800000;
    op = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || temp_result !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_norm_reset got v=%b rdy=%b r=%h exp 0,1,00000000",
               out_valid, in_ready, temp_result);
    end
    applyStimulus(32'h40000000, 32'h40000000, 1'b0, res, lat);
    vectors++;
    if (res !== 32'h40800000 || lat !== 4) begin
      miscompares++;
      $display("[TB] FAIL after_reset_op got=%h lat=%0d exp=40800000 lat=4", res, lat);
    end
  endtask

  // Watchdog that stops a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation timeout");
  end

  // Run every scenario in order and report the totals.
  initial begin
    test_reset();
    test_add_sub();
    test_long_norm();
    test_rounding();
    test_special();
    test_overflow_cancel();
    test_underflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_norm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
